hub75_rx_capture: RTL

- Panel-side receiver for the HUB75 interface driven by `control`.
- Oversamples the shift clock, colour, row-address, OE and LAT lines on the system clock.
- Reconstructs each latched row pair and writes it pixel by pixel into an external frame-buffer write port.
- Used as a panel model in benches and as a loopback checker on hardware.

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/hub75_rx_capture_if.sv | 40 ++++
 rtl/hub75_sync_edge.sv | 37 +++
 rtl/hub75_rx_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 panel-side capture block.
// Contents: default geometry, write-out FSM state encoding, RGB pixel payload.
package hub75_pkg;

  localparam int unsigned COLS_DEF        = 64;
  localparam int unsigned ROW_BITS_DEF    = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_OE = 2'd1,
    WR_TOP  = 2'd2,
    WR_BOT  = 2'd3
  } state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb3_t;

endpackage

// File: rtl/hub75_rx_capture_if.sv
// HUB75 link plus frame-buffer write port seen by the capture block.
// master: panel driver side (drives HUB75 lines, observes writes/status).
// slave : capture side (receives HUB75 lines, drives writes/status).
interface hub75_rx_capture_if #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 4
);
  import hub75_pkg::*;

  localparam int unsigned COL_W = $clog2(COLS);

  // HUB75 lines
  logic hub_sclk;
  logic A, B, C, D;
  logic R0, G0, B0;
  logic R1, G1, B1;
  logic OE;
  logic LAT;

  // Frame-buffer write port and status
  logic                wr_en;
  logic [ROW_BITS:0]   wr_row;
  logic [COL_W-1:0]    wr_col;
  rgb3_t               wr_rgb;
  logic                frame_done;
  logic                busy;
  logic                len_err;
  logic                ovr_err;

  modport master (
    output hub_sclk, A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT,
    input  wr_en, wr_row, wr_col, wr_rgb, frame_done, busy, len_err, ovr_err
  );

  modport slave (
    input  hub_sclk, A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT,
    output wr_en, wr_row, wr_col, wr_rgb, frame_done, busy, len_err, ovr_err
  );

endinterface

// File: rtl/hub75_sync_edge.sv
// N-stage synchronizer with a rising-edge detector on the synchronized copy.
// Ports: clk, rst_n (async active-low), din (async input),
//        sync_o (last synchronizer stage), rise_c (sync_o rose this cycle).
module hub75_sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_c
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  // Shift the input through the stages; prev holds the last stage one cycle late.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], din};
    prev_d  = stage_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_c = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_rx_capture.sv
// HUB75 panel-side receiver: oversamples the HUB75 lines on clk, rebuilds each
// latched row pair and writes it pixel by pixel into a frame-buffer write port.
// Ports: clk, rst (async active-low), bus (hub75_rx_capture_if.slave):
//   in : hub_sclk, A..D, R0/G0/B0, R1/G1/B1, OE, LAT
//   out: wr_en, wr_row, wr_col, wr_rgb, frame_done, busy, len_err, ovr_err
// Build option HUB75_RX_OE_GATE_EN: hold write-out in WAIT_OE until synced OE is low.
module hub75_rx_capture
  import hub75_pkg::*;
#(
  parameter int unsigned COLS        = COLS_DEF,
  parameter int unsigned ROW_BITS    = ROW_BITS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  hub75_rx_capture_if.slave bus
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CNT_W = $clog2(COLS + 2);

  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(COLS);
  localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(COLS + 1);
  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

  // Input synchronization
  logic       sclk_lvl, sclk_rise;
  logic       lat_lvl, lat_rise;
  logic       oe_lvl, oe_rise;
  logic [9:0] data_lvl, data_rise;

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_sclk (
    .clk(clk), .rst_n(rst), .din(bus.hub_sclk), .sync_o(sclk_lvl), .rise_c(sclk_rise)
  );

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_lat (
    .clk(clk), .rst_n(rst), .din(bus.LAT), .sync_o(lat_lvl), .rise_c(lat_rise)
  );

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_oe (
    .clk(clk), .rst_n(rst), .din(bus.OE), .sync_o(oe_lvl), .rise_c(oe_rise)
  );

  // Address and colour share one synchronizer so they stay aligned with sclk/LAT.
  hub75_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(10)) u_sync_data (
    .clk(clk), .rst_n(rst),
    .din({bus.D, bus.C, bus.B, bus.A, bus.R0, bus.G0, bus.B0, bus.R1, bus.G1, bus.B1}),
    .sync_o(data_lvl), .rise_c(data_rise)
  );

`ifdef HUB75_RX_OE_GATE_EN
  logic unused_c;
  assign unused_c = ^{sclk_lvl, lat_lvl, oe_rise, data_rise};
`else
  logic unused_c;
  assign unused_c = ^{sclk_lvl, lat_lvl, oe_lvl, oe_rise, data_rise};
`endif

  logic [ROW_BITS-1:0] row_addr_c;
  rgb3_t               rgb0_c, rgb1_c;

  assign row_addr_c = ROW_BITS'(data_lvl[9:6]);
  assign rgb0_c     = data_lvl[5:3];
  assign rgb1_c     = data_lvl[2:0];

  // State
  rgb3_t [COLS-1:0]    top_sr_q, top_sr_d, bot_sr_q, bot_sr_d;
  rgb3_t [COLS-1:0]    hold_top_q, hold_top_d, hold_bot_q, hold_bot_d;
  logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] last_row_q, last_row_d;
  state_e              state_q, state_d;

  logic                wr_en_q, wr_en_d;
  logic [ROW_BITS:0]   wr_row_q, wr_row_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d;
  rgb3_t               wr_rgb_q, wr_rgb_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                len_err_q, len_err_d;
  logic                ovr_err_q, ovr_err_d;
  logic                accept_c;

  // Shift, latch and write-out sequencing; shift is applied before the latch so a
  // coincident sclk edge lands in the committed row.
  always_comb begin
    top_sr_d     = top_sr_q;
    bot_sr_d     = bot_sr_q;
    hold_top_d   = hold_top_q;
    hold_bot_d   = hold_bot_q;
    shift_cnt_d  = shift_cnt_q;
    row_d        = row_q;
    last_row_d   = last_row_q;
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_row_d     = '0;
    wr_col_d     = '0;
    wr_rgb_d     = '0;
    frame_done_d = 1'b0;
    len_err_d    = len_err_q;
    ovr_err_d    = ovr_err_q;
    accept_c     = 1'b0;

    if (sclk_rise) begin
      top_sr_d = {top_sr_q[COLS-2:0], rgb0_c};
      bot_sr_d = {bot_sr_q[COLS-2:0], rgb1_c};
      if (shift_cnt_q != CNT_SAT) begin
        shift_cnt_d = CNT_W'(shift_cnt_q + 1'b1);
      end
    end

    if (lat_rise) begin
      if (state_q != IDLE) begin
        ovr_err_d = 1'b1;
      end else begin
        accept_c     = 1'b1;
        hold_top_d   = top_sr_d;
        hold_bot_d   = bot_sr_d;
        row_d        = row_addr_c;
        last_row_d   = row_addr_c;
        frame_done_d = (row_addr_c == '0) && (last_row_q == ROW_LAST);
        if (shift_cnt_d != CNT_FULL) begin
          len_err_d = 1'b1;
        end
        shift_cnt_d = '0;
      end
    end

    // Output registers carry the pixel being presented; col 0 is the last-shifted pixel.
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
`ifdef HUB75_RX_OE_GATE_EN
          state_d = WAIT_OE;
`else
          state_d  = WR_TOP;
          wr_en_d  = 1'b1;
          wr_row_d = {1'b0, row_addr_c};
          wr_rgb_d = hold_top_d[0];
`endif
        end
      end
`ifdef HUB75_RX_OE_GATE_EN
      WAIT_OE: begin
        if (!oe_lvl) begin
          state_d  = WR_TOP;
          wr_en_d  = 1'b1;
          wr_row_d = {1'b0, row_q};
          wr_rgb_d = hold_top_q[0];
        end
      end
`endif
      WR_TOP: begin
        wr_en_d = 1'b1;
        if (wr_col_q == COL_LAST) begin
          state_d  = WR_BOT;
          wr_row_d = {1'b1, row_q};
          wr_rgb_d = hold_bot_q[0];
        end else begin
          wr_row_d = {1'b0, row_q};
          wr_col_d = COL_W'(wr_col_q + 1'b1);
          wr_rgb_d = hold_top_q[wr_col_d];
        end
      end
      WR_BOT: begin
        if (wr_col_q == COL_LAST) begin
          state_d = IDLE;
        end else begin
          wr_en_d  = 1'b1;
          wr_row_d = {1'b1, row_q};
          wr_col_d = COL_W'(wr_col_q + 1'b1);
          wr_rgb_d = hold_bot_q[wr_col_d];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_sr_q     <= '0;
      bot_sr_q     <= '0;
      hold_top_q   <= '0;
      hold_bot_q   <= '0;
      shift_cnt_q  <= '0;
      row_q        <= '0;
      last_row_q   <= '0;
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_rgb_q     <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      len_err_q    <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      top_sr_q     <= top_sr_d;
      bot_sr_q     <= bot_sr_d;
      hold_top_q   <= hold_top_d;
      hold_bot_q   <= hold_bot_d;
      shift_cnt_q  <= shift_cnt_d;
      row_q        <= row_d;
      last_row_q   <= last_row_d;
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_rgb_q     <= wr_rgb_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      len_err_q    <= len_err_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_rgb     = wr_rgb_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.len_err    = len_err_q;
  assign bus.ovr_err    = ovr_err_q;

endmodule
